// File: rtl/demux_1x4_stream.sv
// demux_1x4_stream: registered 1-to-N stream demultiplexer.
// One input stream is steered by in_sel into one of N one-entry output
// channels, each with its own valid/ready handshake. A full channel that is
// not draining stalls only the words aimed at it.
module demux_1x4_stream #(
   parameter int WIDTH = 32,
   parameter int SEL_W = 2,
   parameter int CNT_W = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [SEL_W-1:0]              in_sel,
   input  logic [WIDTH-1:0]              in_data,
   output logic [(1<<SEL_W)-1:0]         out_valid,
   input  logic [(1<<SEL_W)-1:0]         out_ready,
   output logic [(1<<SEL_W)*WIDTH-1:0]   out_data,
   output logic [CNT_W-1:0]              xfer_count
);

   localparam int N = 1 << SEL_W;

   logic [N-1:0]            r_valid;
   logic [N-1:0][WIDTH-1:0] r_data;
   logic [CNT_W-1:0]        r_cnt;
   logic                    w_in_ready;
   logic                    w_accept;

   // Target channel can take a word if it is empty or is being drained now.
   // Gated by rst_n so the producer sees no room while reset is held.
   always_comb begin
      w_in_ready = rst_n && (!r_valid[in_sel] || out_ready[in_sel]);
      w_accept   = in_valid && w_in_ready;
   end

   for (genvar k = 0; k < N; k++) begin : g_chan
      logic w_hit;
      assign w_hit = w_accept && (in_sel == SEL_W'(k));

      // Full/empty flag: refill wins over drain so back-to-back words stream.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                         r_valid[k] <= 1'b0;
         else if (w_hit)                     r_valid[k] <= 1'b1;
         else if (r_valid[k] && out_ready[k]) r_valid[k] <= 1'b0;
      end

      // Holding register: only written by an accept to this channel.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)     r_data[k] <= '0;
         else if (w_hit) r_data[k] <= in_data;
      end
   end

   // Accepted-word counter, wraps naturally at 2**CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_cnt <= '0;
      else if (w_accept) r_cnt <= r_cnt + CNT_W'(1);
   end

   assign in_ready   = w_in_ready;
   assign out_valid  = r_valid;
   assign out_data   = r_data;
   assign xfer_count = r_cnt;

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Directed testbench for demux_1x4_stream: table-driven vectors plus
// hand-written sequences for counter wrap and asynchronous reset.
module tb_demux_1x4_stream;

   localparam int WIDTH = 32;
   localparam int SEL_W = 2;
   localparam int CNT_W = 16;
   localparam int N     = 4;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [SEL_W-1:0]   in_sel;
   logic [WIDTH-1:0]   in_data;
   logic [N-1:0]       out_valid;
   logic [N-1:0]       out_ready;
   logic [N*WIDTH-1:0] out_data;
   logic [CNT_W-1:0]   xfer_count;

   int errors = 0;
   int checks = 0;

   demux_1x4_stream #(.WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .xfer_count(xfer_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             vld;
      logic [SEL_W-1:0] sel;
      logic [WIDTH-1:0] data;
      logic [N-1:0]     rdy;
      logic             exp_ir;     // in_ready before the edge
      logic [N-1:0]     exp_valid;  // after the edge
      logic [CNT_W-1:0] exp_cnt;
      int               chk_ch;
      logic [WIDTH-1:0] exp_slice;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] slice(input int ch);
      return out_data[ch*WIDTH +: WIDTH];
   endfunction

   task automatic drive(input logic v, input logic [SEL_W-1:0] s,
                        input logic [WIDTH-1:0] d, input logic [N-1:0] r);
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
   endtask

   initial begin
      //         vld sel data          rdy      ir  valid    cnt ch slice
      vecs[0]  = '{1, 2, 32'hDEADBEEF, 4'b0000, 1, 4'b0100, 1, 2, 32'hDEADBEEF};
      vecs[1]  = '{1, 2, 32'h12345678, 4'b0000, 0, 4'b0100, 1, 2, 32'hDEADBEEF};
      vecs[2]  = '{1, 0, 32'hAAAA0000, 4'b0000, 1, 4'b0101, 2, 0, 32'hAAAA0000};
      vecs[3]  = '{1, 1, 32'h11111111, 4'b0000, 1, 4'b0111, 3, 1, 32'h11111111};
      vecs[4]  = '{1, 1, 32'h00000001, 4'b0010, 1, 4'b0111, 4, 1, 32'h00000001};
      vecs[5]  = '{1, 1, 32'h00000002, 4'b0010, 1, 4'b0111, 5, 1, 32'h00000002};
      vecs[6]  = '{1, 1, 32'h00000003, 4'b0010, 1, 4'b0111, 6, 1, 32'h00000003};
      vecs[7]  = '{0, 2, 32'hFFFFFFFF, 4'b0110, 1, 4'b0001, 6, 2, 32'hDEADBEEF};
      vecs[8]  = '{1, 3, 32'h33333333, 4'b0000, 1, 4'b1001, 7, 3, 32'h33333333};
      vecs[9]  = '{1, 1, 32'h55555555, 4'b1001, 1, 4'b0010, 8, 1, 32'h55555555};
      vecs[10] = '{0, 0, 32'h0BADF00D, 4'b1101, 1, 4'b0010, 8, 0, 32'hAAAA0000};
      vecs[11] = '{1, 1, 32'h66666666, 4'b0000, 0, 4'b0010, 8, 1, 32'h55555555};
      vecs[12] = '{0, 1, 32'h77777777, 4'b0000, 0, 4'b0010, 8, 1, 32'h55555555};

      // Reset state, no clock edge needed
      rst_n = 1'b0;
      drive(1'b1, 2'd0, 32'h0, 4'b1111);
      #3;
      chk("rst_valid", 128'(out_valid), 128'(4'b0000));
      chk("rst_data", 128'(out_data), 128'h0);
      chk("rst_count", 128'(xfer_count), 128'h0);
      chk("rst_in_ready", 128'(in_ready), 128'(1'b0));
      drive(1'b0, 2'd0, 32'h0, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven vectors
      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].rdy);
         #1;
         chk($sformatf("v%0d_in_ready", i), 128'(in_ready), 128'(vecs[i].exp_ir));
         @(posedge clk); #1;
         chk($sformatf("v%0d_out_valid", i), 128'(out_valid), 128'(vecs[i].exp_valid));
         chk($sformatf("v%0d_count", i), 128'(xfer_count), 128'(vecs[i].exp_cnt));
         chk($sformatf("v%0d_slice%0d", i, vecs[i].chk_ch),
             128'(slice(vecs[i].chk_ch)), 128'(vecs[i].exp_slice));
      end
      chk("untouched_slice3", 128'(slice(3)), 128'h33333333);

      // Async reset mid-operation with all channels full
      drive(1'b0, 2'd0, 32'h0, 4'b0000);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
         drive(1'b1, SEL_W'(k), 32'hC0DE0000 + k, 4'b0000);
         @(posedge clk); #1;
      end
      drive(1'b0, 2'd0, 32'h0, 4'b0000);
      chk("full_valid", 128'(out_valid), 128'(4'b1111));
      chk("full_count", 128'(xfer_count), 128'd4);
      chk("full_slice3", 128'(slice(3)), 128'hC0DE0003);
      drive(1'b1, 2'd0, 32'h12121212, 4'b1111);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid", 128'(out_valid), 128'(4'b0000));
      chk("async_data", 128'(out_data), 128'h0);
      chk("async_count", 128'(xfer_count), 128'h0);
      chk("async_in_ready", 128'(in_ready), 128'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("release_in_ready", 128'(in_ready), 128'(1'b1));
      @(posedge clk); #1;
      chk("post_rst_count", 128'(xfer_count), 128'd1);
      chk("post_rst_slice0", 128'(slice(0)), 128'h12121212);

      // Counter wrap: stream into channel 0 with its consumer always ready
      drive(1'b0, 2'd0, 32'h0, 4'b0000);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      drive(1'b1, 2'd0, 32'h0000CAFE, 4'b0001);
      repeat (65535) @(posedge clk);
      #1;
      chk("wrap_pre_count", 128'(xfer_count), 128'hFFFF);
      chk("wrap_in_ready", 128'(in_ready), 128'(1'b1));
      @(posedge clk); #1;
      chk("wrap_count", 128'(xfer_count), 128'h0000);
      drive(1'b0, 2'd0, 32'h0, 4'b0001);
      @(posedge clk); #1;
      chk("wrap_drained", 128'(out_valid), 128'(4'b0000));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
